// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_INT_EN to build the Count/Compare timer and its interrupt (TI).
module cp0_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  input  logic        wr_exp,
  input  logic [4:0]  exp_code,
  input  logic [31:0] epc,
  input  logic        exp_bd,
  input  logic        badvaddr_we,
  input  logic [31:0] badvaddr,
  input  logic        clear_exl,
  output logic [31:0] epc_out,
  output logic        allow_int,
  output logic [7:0]  interrupt_flag
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;

  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  exc_code_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        ti;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;
  logic        mtc0_ok;

  // An MTC0 alongside an exception or ERET belongs to a flushed instruction.
  assign mtc0_ok = mtc0_we & ~wr_exp & ~clear_exl;

`ifdef CP0_TIMER_INT_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        toggle_q;
  logic        ti_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      if (mtc0_ok && mtc0_addr == AddrCount) begin
        count_q  <= mtc0_wdata;
        toggle_q <= 1'b0;
      end else begin
        toggle_q <= ~toggle_q;
        if (toggle_q) count_q <= count_q + 32'd1;
      end
      // Compare write clears TI and beats a same-cycle match.
      if (mtc0_ok && mtc0_addr == AddrCompare) begin
        compare_q <= mtc0_wdata;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      ip_hw_q <= {hw_int[5] | ti, hw_int[4:0]};
      if (badvaddr_we) badvaddr_q <= badvaddr;
      if (wr_exp) begin
        exc_code_q <= exp_code;
        exl_q      <= 1'b1;
        // wr_exp is level; only the first cycle of a nested-free entry captures EPC/BD.
        if (!exl_q) begin
          epc_q <= epc;
          bd_q  <= exp_bd;
        end
      end else if (clear_exl) begin
        exl_q <= 1'b0;
      end else if (mtc0_we) begin
        case (mtc0_addr)
          AddrStatus: begin
            im_q  <= mtc0_wdata[15:8];
            exl_q <= mtc0_wdata[1];
            ie_q  <= mtc0_wdata[0];
          end
          AddrCause: ip_sw_q <= mtc0_wdata[9:8];
          AddrEpc:   epc_q   <= mtc0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mfc0_rdata = 32'd0;
    case (mfc0_addr)
      AddrBadVAddr: mfc0_rdata = badvaddr_q;
      AddrCount:    mfc0_rdata = count_rd;
      AddrCompare:  mfc0_rdata = compare_rd;
      AddrStatus:   mfc0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
      AddrCause:    mfc0_rdata = {bd_q, ti, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};
      AddrEpc:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = 32'd0;
    endcase
  end

  assign epc_out        = epc_q;
  assign allow_int      = ie_q & ~exl_q;
  assign interrupt_flag = {ip_hw_q, ip_sw_q} & im_q;

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS core, sitting directly downstream of the exception unit. Commits the exception unit's per-cycle results (`wr_exp`, `exp_code`, `epc`, `badvaddr`, `clear_exl`) into architectural CP0 state. Also serves MFC0/MTC0 from the pipeline and feeds `epc_out`, `allow_int` and `interrupt_flag` back to the exception unit. Implements BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14).

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock
- `resetn`  in  1  reset, synchronous, active-low
- `hw_int`  in  6  external interrupt lines, level
- `mtc0_we`  in  1  MTC0 write strobe
- `mtc0_addr`  in  5  MTC0 register number (rd)
- `mtc0_wdata`  in  32  MTC0 data
- `mfc0_addr`  in  5  MFC0 register number
- `mfc0_rdata`  out  32  MFC0 data; combinational
- `wr_exp`  in  1  exception commit, level
- `exp_code`  in  5  ExcCode to record
- `epc`  in  32  EPC value from exception unit
- `exp_bd`  in  1  faulting instruction is in a delay slot
- `badvaddr_we`  in  1  BadVAddr write enable
- `badvaddr`  in  32  BadVAddr value
- `clear_exl`  in  1  ERET commit
- `epc_out`  out  32  EPC register; drives exception unit `epc_in`
- `allow_int`  out  1  Status.IE & ~Status.EXL
- `interrupt_flag`  out  8  Cause.IP & Status.IM

## Operation
Field layout:
- Status: BEV[22] read-only 1; IM[15:8] RW; EXL[1] RW; IE[0] RW; all other bits read 0.
- Cause: BD[31] RO; TI[30] RO; IP[15:10] RO, hardware; IP[9:8] RW, software; ExcCode[6:2] RO; all other bits read 0.
- BadVAddr: RO to MTC0. EPC, Count, Compare: RW.

Hardware IP:
- Each cycle IP[15:10] <= {hw_int[5] | TI, hw_int[4:0]}.

Exception commit (`wr_exp`=1):
- ExcCode <= `exp_code`; EXL <= 1.
- If EXL was 0: EPC <= `epc`, BD <= `exp_bd`.
- If EXL was already 1: EPC and BD are held. Because `wr_exp` is level and may stay high several cycles, only the first cycle captures EPC.
- `badvaddr_we`=1 loads BadVAddr independently of `wr_exp`.

ERET and priority:
- `clear_exl`=1: EXL <= 0. The exception unit never asserts it together with `wr_exp`; if both are high, `wr_exp` wins.
- `wr_exp` or `clear_exl` high: any same-cycle MTC0 is dropped, because that instruction is flushed.
- Otherwise MTC0 writes only the RW fields.
- MTC0 to an unimplemented register, or to RO fields, is ignored.

Reads:
- Unimplemented registers read 0.
- `mfc0_rdata` reflects current register contents; no bypass of a same-cycle MTC0.

## Timing
- All state updates land at the clk edge where the strobe is sampled, and are visible the next cycle.
- `allow_int`, `interrupt_flag` and `epc_out` are combinational from registers.
- hw_int to `interrupt_flag` latency: 1 cycle.
- Count increments on every second cycle via an internal toggle bit; it wraps 0xFFFF_FFFF -> 0.
- TI sets on the cycle after Count == Compare. A Compare write clears TI, and the clear wins over a same-cycle set.
- An MTC0 to Count loads Count and resets the toggle.

Reset values (resetn=0 at an edge):
- Status = 0x0040_0000; Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 0; toggle = 0.
- Outputs after reset: `allow_int`=0; `interrupt_flag`=0; `epc_out`=0.
- Reset mid-exception takes precedence over everything.

## Configuration
- `CP0_TIMER_INT_EN` defined: Count/Compare/TI implemented as above.
- `CP0_TIMER_INT_EN` undefined: registers 9 and 11 read 0 and ignore writes; TI is constant 0; IP[15] = hw_int[5] only.

## Test plan
- Reset -> Status=0x0040_0000, Cause=0, `allow_int`=0, `interrupt_flag`=0x00.
- MTC0 Status=0x0000_FF01, then hw_int=6'b000001 -> IP[10] set one cycle later; `interrupt_flag`=0x04; `allow_int`=1.
- `wr_exp`=1 held 3 cycles, exp_code=0x04, epc=0xBFC0_0100, exp_bd=1, badvaddr_we=1, badvaddr=0x0000_0003 -> EPC=0xBFC0_0100, Cause=0x8000_0010, EXL=1, BadVAddr=3; a changed `epc` in cycles 2–3 is ignored.
- `clear_exl`=1 -> EXL=0, `allow_int`=1; MTC0 EPC in same cycle as `wr_exp` -> dropped.
- (timer on) MTC0 Compare=10, Count=0 -> TI=1 about 21 cycles later, `interrupt_flag`[7]=1 with IM7 set; MTC0 Compare -> TI=0 next cycle.
- (timer off) MTC0 Count=5 -> MFC0 Count returns 0.
